// File: rtl/stream_upsizer.sv
// stream_upsizer: packs RATIO consecutive narrow beats into one wide beat.
//
// Lane 0 of a wide word is the first narrow beat and sits in the LSBs. A packet
// whose length is not a multiple of RATIO closes with a partial wide beat: only
// the filled lanes have keep set and the empty lanes read as zero.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   valid_src  narrow beat valid
//   ready_src  narrow beat accepted when valid_src && ready_src
//   src        narrow beat data (W_IN bits)
//   src_last   final narrow beat of a packet
//   valid_dst  wide beat valid (registered)
//   ready_dst  downstream ready
//   dst        wide beat data; lane k = dst[k*W_IN +: W_IN] (registered)
//   dst_keep   per-lane valid mask, always contiguous from bit 0 (registered)
//   dst_last   wide beat holds the final narrow beat of a packet (registered)
module stream_upsizer #(
   parameter int unsigned W_IN  = 32,
   parameter int unsigned RATIO = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_src,
   output logic                  ready_src,
   input  logic [W_IN-1:0]       src,
   input  logic                  src_last,
   output logic                  valid_dst,
   input  logic                  ready_dst,
   output logic [W_IN*RATIO-1:0] dst,
   output logic [RATIO-1:0]      dst_keep,
   output logic                  dst_last
);

   localparam int unsigned W_OUT = W_IN * RATIO;
   localparam int unsigned CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [CW-1:0] LAST_LANE = CW'(RATIO - 1);

   // Accumulator for the wide word under construction
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [W_OUT-1:0] acc_q, acc_d;
   logic [RATIO-1:0] acc_keep_q, acc_keep_d;

   // Output register
   logic             valid_q, valid_d;
   logic [W_OUT-1:0] dst_q, dst_d;
   logic [RATIO-1:0] keep_q, keep_d;
   logic             last_q, last_d;

   logic             accept;
   logic             completing;
   logic [W_OUT-1:0] merged;
   logic [RATIO-1:0] merged_keep;

   // Accept whenever the output register is empty or drains this cycle.
   assign ready_src  = !valid_q || ready_dst;
   assign accept     = valid_src && ready_src;
   assign completing = (cnt_q == LAST_LANE) || src_last;

   // Accumulator with lane cnt replaced by src; lanes above cnt forced to zero.
   // Serves both as the next accumulator value and as the emitted wide word.
   always_comb begin
      merged      = '0;
      merged_keep = '0;
      for (int k = 0; k < int'(RATIO); k++) begin
         if (CW'(k) < cnt_q) begin
            merged[k*W_IN +: W_IN] = acc_q[k*W_IN +: W_IN];
            merged_keep[k]         = acc_keep_q[k];
         end else if (CW'(k) == cnt_q) begin
            merged[k*W_IN +: W_IN] = src;
            merged_keep[k]         = 1'b1;
         end
      end
   end

   always_comb begin
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      acc_keep_d = acc_keep_q;
      valid_d    = valid_q;
      dst_d      = dst_q;
      keep_d     = keep_q;
      last_d     = last_q;

      if (valid_q && ready_dst) begin
         valid_d = 1'b0;
      end

      if (accept) begin
         if (completing) begin
            // A completing accept reloads the output register even while the
            // previous beat drains, giving back-to-back wide beats.
            dst_d      = merged;
            keep_d     = merged_keep;
            last_d     = src_last;
            valid_d    = 1'b1;
            acc_d      = '0;
            acc_keep_d = '0;
            cnt_d      = '0;
         end else begin
            acc_d      = merged;
            acc_keep_d = merged_keep;
            cnt_d      = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         acc_q      <= '0;
         acc_keep_q <= '0;
         valid_q    <= 1'b0;
         dst_q      <= '0;
         keep_q     <= '0;
         last_q     <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         acc_keep_q <= acc_keep_d;
         valid_q    <= valid_d;
         dst_q      <= dst_d;
         keep_q     <= keep_d;
         last_q     <= last_d;
      end
   end

   assign valid_dst = valid_q;
   assign dst       = dst_q;
   assign dst_keep  = keep_q;
   assign dst_last  = last_q;

endmodule

// File: tb/tb_stream_upsizer.sv
// Testbench for stream_upsizer with W_IN=8, RATIO=4: directed scenarios plus a
// randomized run checked against a packet-level reference model.
module tb_stream_upsizer;

   localparam int unsigned W  = 8;
   localparam int unsigned R  = 4;
   localparam int unsigned DW = W * R;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          valid_src;
   logic          ready_src;
   logic [W-1:0]  src;
   logic          src_last;
   logic          valid_dst;
   logic          ready_dst;
   logic [DW-1:0] dst;
   logic [R-1:0]  dst_keep;
   logic          dst_last;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [DW-1:0] data;
      logic [R-1:0]  keep;
      logic          last;
   } wide_t;

   always #5 clk = ~clk;

   stream_upsizer #(
      .W_IN  (W),
      .RATIO (R)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_src (valid_src),
      .ready_src (ready_src),
      .src       (src),
      .src_last  (src_last),
      .valid_dst (valid_dst),
      .ready_dst (ready_dst),
      .dst       (dst),
      .dst_keep  (dst_keep),
      .dst_last  (dst_last)
   );

   // Present one beat for one clock edge; caller ensures ready_src is high.
   task automatic drive(input logic [W-1:0] d, input logic l);
      valid_src = 1'b1;
      src       = d;
      src_last  = l;
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      valid_src = 1'b0;
      src_last  = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      valid_src = 1'b0;
      src       = 8'hEE;
      src_last  = 1'b1;
      ready_dst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if (valid_dst !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %0h expected 0", valid_dst);
      end
      n_checks++;
      if (dst !== '0) begin
         n_fail++; $display("FAIL reset_dst: got %0h expected 0", dst);
      end
      n_checks++;
      if (dst_keep !== '0 || dst_last !== 1'b0) begin
         n_fail++; $display("FAIL reset_keep_last: got %0h/%0h expected 0/0", dst_keep, dst_last);
      end
      rst_n = 1'b1;
      // Junk data without valid_src must be ignored.
      for (int i = 0; i < 3; i++) begin
         src      = 8'($urandom);
         src_last = 1'($urandom);
         @(posedge clk);
         #1;
      end
      src_last = 1'b0;
      n_checks++;
      if (valid_dst !== 1'b0 || ready_src !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_ignore: got valid=%0h ready=%0h expected 0/1", valid_dst, ready_src);
      end
   endtask

   task automatic test_fill();
      drive(8'h11, 1'b0);
      drive(8'h22, 1'b0);
      drive(8'h33, 1'b0);
      n_checks++;
      if (valid_dst !== 1'b0) begin
         n_fail++; $display("FAIL fill_early_valid: got %0h expected 0", valid_dst);
      end
      drive(8'h44, 1'b1);
      valid_src = 1'b0;
      n_checks++;
      if (valid_dst !== 1'b1 || dst !== 32'h44332211) begin
         n_fail++;
         $display("FAIL fill_data: got valid=%0h dst=%0h expected 1/44332211", valid_dst, dst);
      end
      n_checks++;
      if (dst_keep !== 4'b1111 || dst_last !== 1'b1) begin
         n_fail++; $display("FAIL fill_keep_last: got %0h/%0h expected f/1", dst_keep, dst_last);
      end
      idle();
      n_checks++;
      if (valid_dst !== 1'b0) begin
         n_fail++; $display("FAIL fill_one_cycle: got %0h expected 0", valid_dst);
      end
   endtask

   task automatic test_partial();
      drive(8'hA1, 1'b0);
      drive(8'hA2, 1'b1);
      n_checks++;
      if (valid_dst !== 1'b1 || dst !== 32'h0000A2A1 || dst_keep !== 4'b0011 || dst_last !== 1'b1)
      begin
         n_fail++;
         $display("FAIL partial_two: got v=%0h d=%0h k=%0h l=%0h expected 1/a2a1/3/1",
                  valid_dst, dst, dst_keep, dst_last);
      end
      drive(8'hB1, 1'b1);
      valid_src = 1'b0;
      n_checks++;
      if (valid_dst !== 1'b1 || dst !== 32'h000000B1 || dst_keep !== 4'b0001 || dst_last !== 1'b1)
      begin
         n_fail++;
         $display("FAIL partial_single: got v=%0h d=%0h k=%0h l=%0h expected 1/b1/1/1",
                  valid_dst, dst, dst_keep, dst_last);
      end
      idle();
   endtask

   task automatic test_back_to_back();
      int stalls = 0;
      for (int i = 1; i <= 8; i++) begin
         if (ready_src !== 1'b1) stalls++;
         drive(8'(i), i == 8);
         if (i == 4) begin
            n_checks++;
            if (valid_dst !== 1'b1 || dst !== 32'h04030201 || dst_keep !== 4'b1111 ||
                dst_last !== 1'b0) begin
               n_fail++;
               $display("FAIL b2b_first: got v=%0h d=%0h k=%0h l=%0h expected 1/4030201/f/0",
                        valid_dst, dst, dst_keep, dst_last);
            end
         end
      end
      valid_src = 1'b0;
      n_checks++;
      if (valid_dst !== 1'b1 || dst !== 32'h08070605 || dst_keep !== 4'b1111 || dst_last !== 1'b1)
      begin
         n_fail++;
         $display("FAIL b2b_second: got v=%0h d=%0h k=%0h l=%0h expected 1/8070605/f/1",
                  valid_dst, dst, dst_keep, dst_last);
      end
      n_checks++;
      if (stalls != 0) begin
         n_fail++; $display("FAIL b2b_ready: got %0d stalled cycles expected 0", stalls);
      end
      idle();
   endtask

   task automatic test_backpressure();
      ready_dst = 1'b0;
      drive(8'h01, 1'b0);
      drive(8'h02, 1'b0);
      drive(8'h03, 1'b0);
      drive(8'h04, 1'b0);
      valid_src = 1'b1;
      src       = 8'h05;
      src_last  = 1'b0;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (ready_src !== 1'b0) begin
            n_fail++; $display("FAIL bp_ready_low: got %0h expected 0 (cycle %0d)", ready_src, i);
         end
         n_checks++;
         if (valid_dst !== 1'b1 || dst !== 32'h04030201 || dst_keep !== 4'b1111 ||
             dst_last !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold: got v=%0h d=%0h k=%0h l=%0h expected 1/4030201/f/0",
                     valid_dst, dst, dst_keep, dst_last);
         end
         @(posedge clk);
         #1;
      end
      ready_dst = 1'b1;
      #1;
      n_checks++;
      if (ready_src !== 1'b1) begin
         n_fail++; $display("FAIL bp_ready_release: got %0h expected 1", ready_src);
      end
      @(posedge clk);
      #1;
      n_checks++;
      if (valid_dst !== 1'b0) begin
         n_fail++; $display("FAIL bp_consumed_once: got %0h expected 0", valid_dst);
      end
      drive(8'h06, 1'b0);
      drive(8'h07, 1'b0);
      drive(8'h08, 1'b1);
      valid_src = 1'b0;
      n_checks++;
      if (valid_dst !== 1'b1 || dst !== 32'h08070605 || dst_keep !== 4'b1111 || dst_last !== 1'b1)
      begin
         n_fail++;
         $display("FAIL bp_resume: got v=%0h d=%0h k=%0h l=%0h expected 1/8070605/f/1",
                  valid_dst, dst, dst_keep, dst_last);
      end
      idle();
   endtask

   task automatic test_reset_mid_packet();
      drive(8'h11, 1'b0);
      drive(8'h22, 1'b0);
      valid_src = 1'b0;
      rst_n     = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      n_checks++;
      if (valid_dst !== 1'b0 || dst !== '0 || dst_keep !== '0 || dst_last !== 1'b0) begin
         n_fail++;
         $display("FAIL midreset_clear: got v=%0h d=%0h k=%0h l=%0h expected all 0",
                  valid_dst, dst, dst_keep, dst_last);
      end
      drive(8'h33, 1'b1);
      valid_src = 1'b0;
      n_checks++;
      if (valid_dst !== 1'b1 || dst !== 32'h00000033 || dst_keep !== 4'b0001 || dst_last !== 1'b1)
      begin
         n_fail++;
         $display("FAIL midreset_out: got v=%0h d=%0h k=%0h l=%0h expected 1/33/1/1",
                  valid_dst, dst, dst_keep, dst_last);
      end
      idle();
   endtask

   task automatic test_random();
      logic [W-1:0] in_data[$];
      logic         in_last[$];
      wide_t        exp_q[$];
      wide_t        w;
      wide_t        got;
      int           base;
      int           len;
      int           idx;
      int           cycles;
      int           n;

      // Reference: split each packet into groups of R bytes, last group partial.
      base = 0;
      while (in_data.size() < 2000) begin
         len = $urandom_range(1, 13);
         for (int b = 0; b < len; b++) begin
            in_data.push_back(8'($urandom));
            in_last.push_back(b == len - 1);
         end
         for (int s = 0; s < len; s += R) begin
            w.data = '0;
            w.keep = '0;
            for (int j = 0; j < int'(R) && s + j < len; j++) begin
               w.data[j*W +: W] = in_data[base + s + j];
               w.keep[j]        = 1'b1;
            end
            w.last = (s + int'(R) >= len);
            exp_q.push_back(w);
         end
         base += len;
      end
      n = in_data.size();

      idx    = 0;
      cycles = 0;
      while ((idx < n || exp_q.size() != 0) && cycles < 30000) begin
         valid_src = (idx < n) && ($urandom_range(0, 1) == 1);
         src       = valid_src ? in_data[idx] : 8'($urandom);
         src_last  = valid_src ? in_last[idx] : 1'($urandom);
         ready_dst = 1'($urandom_range(0, 1));
         @(negedge clk);
         n_checks++;
         if (ready_src !== (!valid_dst || ready_dst)) begin
            n_fail++;
            $display("FAIL rand_ready: got %0h expected %0h", ready_src, !valid_dst || ready_dst);
         end
         if (valid_dst === 1'b1 && ready_dst) begin
            got.data = dst;
            got.keep = dst_keep;
            got.last = dst_last;
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rand_extra_beat: got %0h expected none", got.data);
            end else begin
               w = exp_q.pop_front();
               if (got.data !== w.data || got.keep !== w.keep || got.last !== w.last) begin
                  n_fail++;
                  $display("FAIL rand_beat: got d=%0h k=%0h l=%0h expected d=%0h k=%0h l=%0h",
                           got.data, got.keep, got.last, w.data, w.keep, w.last);
               end
            end
            n_checks++;
            if (got.keep == '0 || ((got.keep + 1'b1) & got.keep) != '0) begin
               n_fail++; $display("FAIL rand_keep_contig: got %0h expected 2^n-1", got.keep);
            end
         end
         if (valid_src && ready_src === 1'b1) idx++;
         @(posedge clk);
         #1;
         cycles++;
      end
      n_checks++;
      if (idx < n || exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL rand_timeout: got %0d beats sent, %0d wide pending expected %0d/0",
                  idx, exp_q.size(), n);
      end
      valid_src = 1'b0;
      ready_dst = 1'b1;
   endtask

   initial begin
      test_reset();
      test_fill();
      test_partial();
      test_back_to_back();
      test_backpressure();
      test_reset_mid_packet();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/stream_upsizer.md
Name: stream_upsizer

Overview:
- Handshake-based stream width converter. Packs RATIO consecutive narrow beats of W_IN bits into one wide beat of W_IN*RATIO bits, with a per-lane keep mask and a last flag.
- Sits directly downstream of a register stage on a narrow stream, for example between a narrow ingress path and a wide packet datapath.
- Packets whose length is not a multiple of RATIO finish with a partial wide beat: only the filled lanes have keep set, and the empty lanes read as zero.

Parameters:
- W_IN, 32, width of one narrow input beat in bits (>=1).
- RATIO, 4, number of narrow beats per wide beat (>=2). Output data width is W_IN*RATIO.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- valid_src  input  1  narrow input beat valid.
- ready_src  output  1  narrow input beat accepted when valid_src && ready_src.
- src  input  W_IN  narrow input data.
- src_last  input  1  marks the final narrow beat of a packet.
- valid_dst  output  1  wide output beat valid.
- ready_dst  input  1  downstream ready.
- dst  output  W_IN*RATIO  wide output data; lane k = dst[k*W_IN +: W_IN].
- dst_keep  output  RATIO  lane k holds valid data when dst_keep[k]=1.
- dst_last  output  1  wide beat contains the final narrow beat of a packet.

Behaviour:
- Reset (rst_n=0 at a clk edge) clears:
  - valid_dst=0, dst=0, dst_keep=0, dst_last=0;
  - lane counter=0, accumulator data=0, accumulator keep=0.
  - Reset mid-packet discards any partial accumulation; no beat is emitted for it.
- ready_src = !valid_dst || ready_dst. It is combinational from registered state and ready_dst only, never from valid_src or src.
- Lane counter cnt runs 0..RATIO-1. Lane 0 is the first narrow beat of a wide word and occupies the LSBs.
- Accepted beat that is non-completing (cnt<RATIO-1 and !src_last):
  - acc lane cnt <= src;
  - acc_keep[cnt] <= 1;
  - cnt <= cnt+1.
  - The output register is unaffected.
- Accepted beat that is completing (cnt==RATIO-1 or src_last):
  - dst <= acc with lane cnt replaced by src, and lanes above cnt forced to 0;
  - dst_keep <= acc_keep | (1<<cnt);
  - dst_last <= src_last;
  - valid_dst <= 1;
  - acc data and acc_keep <= 0, cnt <= 0.
- Latency: the completing beat accepted at edge t gives valid_dst=1 after edge t, i.e. one cycle.
- Output handshake:
  - When valid_dst && ready_dst and no completing beat is accepted at the same edge, valid_dst <= 0.
  - When a completing beat is accepted at the same edge, the output register reloads and valid_dst stays 1. This is back-to-back operation with no bubble.
- Stall: while valid_dst && !ready_dst:
  - ready_src=0;
  - dst, dst_keep and dst_last hold stable;
  - accumulation pauses.
- Keep pattern: dst_keep is always contiguous from bit 0, i.e. of the form 2^n-1.
- Single-beat packet (src_last on the first beat): dst_keep=1, lanes 1..RATIO-1 are 0.
- Throughput: with ready_dst held at 1, one narrow beat is accepted every cycle; wide beats are emitted every RATIO cycles, or sooner at packet ends.
- valid_src deasserted mid-word: accumulation simply waits. There is no timeout and no flush.
- Data is never dropped or duplicated. src values presented without valid_src are ignored.

Test Plan:
1. Fill: W_IN=8, RATIO=4, ready_dst=1; send 0x11,0x22,0x33,0x44 (last on 0x44) in consecutive cycles -> one cycle after the 4th accept, valid_dst=1, dst=0x44332211, dst_keep=4'b1111, dst_last=1, held for exactly 1 cycle.
2. Partial: send 0xA1,0xA2 with src_last on 0xA2 -> dst=0x0000A2A1, dst_keep=4'b0011, dst_last=1. The next packet 0xB1 alone (last) -> dst=0x000000B1, dst_keep=4'b0001.
3. Back-to-back: 8 beats 0x01..0x08 continuous, last on 0x08, ready_dst=1 -> two wide beats, 0x04030201 (keep 1111, last 0) then 0x08070605 (keep 1111, last 1), with ready_src never 0.
4. Backpressure: hold ready_dst=0 for 5 cycles while the first wide beat is valid -> ready_src=0 and dst/dst_keep/dst_last stable through the stall. On the ready_dst rise, the beat is consumed once and the input resumes with no lost or repeated beats (compare against a scoreboard).
5. Reset mid-packet: accept 0x11,0x22, drive rst_n=0 for 1 cycle, then send 0x33 (last) -> all outputs 0 after the reset edge; the only output is dst=0x00000033, dst_keep=4'b0001, dst_last=1.
6. Random: 2000 beats with random valid_src/ready_dst (50%) and random packet lengths 1..13 -> the reassembled byte stream and packet boundaries match the scoreboard, and dst_keep is contiguous in every beat.
